// File: rtl/ahb_sram_banked_if.sv
// AHB-Lite slave bus plus the shared SRAM macro port of the banked SRAM bridge.
interface ahb_sram_banked_if #(
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned BANK_AW   = 11
);
  logic                     HSEL;
  logic [31:0]              HADDR;
  logic [1:0]               HTRANS;
  logic                     HWRITE;
  logic [2:0]               HSIZE;
  logic [31:0]              HWDATA;
  logic                     HREADY;
  logic                     HREADYOUT;
  logic                     HRESP;
  logic [31:0]              HRDATA;
  logic [NUM_BANKS-1:0]     SRAM_EN;
  logic [3:0]               SRAM_WE;
  logic [BANK_AW-1:0]       SRAM_A;
  logic [31:0]              SRAM_DI;
  logic [32*NUM_BANKS-1:0]  SRAM_DO;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY, SRAM_DO,
    output HREADYOUT, HRESP, HRDATA, SRAM_EN, SRAM_WE, SRAM_A, SRAM_DI
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY, SRAM_DO,
    input  HREADYOUT, HRESP, HRDATA, SRAM_EN, SRAM_WE, SRAM_A, SRAM_DI
  );
endinterface

// File: rtl/ahb_sram_banked.sv
// AHB-Lite slave in front of NUM_BANKS single-port SRAM banks. Zero-wait reads and writes;
// a write whose data phase collides with a read address phase is parked in a one-entry
// buffer, forwarded to reads, and committed on the next free SRAM cycle.
module ahb_sram_banked #(
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned BANK_AW   = 11
) (
  input logic              HCLK,
  input logic              HRESET,
  ahb_sram_banked_if.slave bus
);
  localparam int unsigned BSW = $clog2(NUM_BANKS);

  typedef enum logic [1:0] {StOkay, StErr1, StErr2} err_state_e;

  // Address phase decode
  logic               accept, illegal, rd_ap, wr_ap, err_ap;
  logic [BSW-1:0]     ap_bank;
  logic [BANK_AW-1:0] ap_word;
  logic [3:0]         ap_mask;

  // Data phase context
  logic               dp_rd_q, dp_rd_d, dp_wr_q, dp_wr_d;
  logic [BSW-1:0]     dp_bank_q, dp_bank_d;
  logic [BANK_AW-1:0] dp_word_q, dp_word_d;
  logic [3:0]         dp_mask_q, dp_mask_d;

  // Write buffer
  logic               wb_valid_q, wb_valid_d;
  logic [BSW-1:0]     wb_bank_q, wb_bank_d;
  logic [BANK_AW-1:0] wb_word_q, wb_word_d;
  logic [3:0]         wb_mask_q, wb_mask_d;
  logic [31:0]        wb_data_q, wb_data_d;

  err_state_e         state_q, state_d;

  logic [NUM_BANKS-1:0] sram_en;
  logic [3:0]           sram_we;
  logic [BANK_AW-1:0]   sram_a;
  logic [31:0]          sram_di;
  logic [31:0]          rd_word;
  logic [31:0]          hrdata;
  logic                 fwd_hit;

  // Upper address bits alias and HTRANS[0] (SEQ vs NONSEQ) does not matter here.
  logic unused_bits;
  assign unused_bits = ^{bus.HTRANS[0], bus.HADDR[31:BANK_AW+2+BSW]};

  // Decode the address phase: bank/word split, byte mask and legality.
  always_comb begin
    ap_word = bus.HADDR[BANK_AW+1:2];
    ap_bank = bus.HADDR[BANK_AW+2 +: BSW];
    case (bus.HSIZE)
      3'd0:    ap_mask = 4'b0001 << bus.HADDR[1:0];
      3'd1:    ap_mask = bus.HADDR[1] ? 4'b1100 : 4'b0011;
      default: ap_mask = 4'b1111;
    endcase
    illegal = (bus.HSIZE > 3'd2) ||
              ((bus.HSIZE == 3'd1) && bus.HADDR[0]) ||
              ((bus.HSIZE == 3'd2) && (bus.HADDR[1:0] != 2'b00));
    accept  = bus.HSEL && bus.HREADY && bus.HTRANS[1];
    rd_ap   = accept && !illegal && !bus.HWRITE;
    wr_ap   = accept && !illegal &&  bus.HWRITE;
    err_ap  = accept &&  illegal;
  end

  // Next-state for the data-phase context and the write buffer.
  always_comb begin
    dp_rd_d    = rd_ap;
    dp_wr_d    = wr_ap;
    dp_bank_d  = dp_bank_q;
    dp_word_d  = dp_word_q;
    dp_mask_d  = dp_mask_q;
    wb_valid_d = wb_valid_q;
    wb_bank_d  = wb_bank_q;
    wb_word_d  = wb_word_q;
    wb_mask_d  = wb_mask_q;
    wb_data_d  = wb_data_q;
    if (rd_ap || wr_ap) begin
      dp_bank_d = ap_bank;
      dp_word_d = ap_word;
      dp_mask_d = ap_mask;
    end
    if (dp_wr_q && rd_ap) begin
      // The read owns the port this cycle; park the write.
      wb_valid_d = 1'b1;
      wb_bank_d  = dp_bank_q;
      wb_word_d  = dp_word_q;
      wb_mask_d  = dp_mask_q;
      wb_data_d  = bus.HWDATA;
    end else if (wb_valid_q && !rd_ap && !dp_wr_q) begin
      wb_valid_d = 1'b0;
    end
  end

  // SRAM port arbitration: read address phase, then direct write, then buffer drain.
  always_comb begin
    sram_en = '0;
    sram_we = '0;
    sram_a  = '0;
    sram_di = '0;
    if (!HRESET) begin
      if (rd_ap) begin
        sram_en[ap_bank] = 1'b1;
        sram_a           = ap_word;
      end else if (dp_wr_q) begin
        sram_en[dp_bank_q] = 1'b1;
        sram_we            = dp_mask_q;
        sram_a             = dp_word_q;
        sram_di            = bus.HWDATA;
      end else if (wb_valid_q) begin
        sram_en[wb_bank_q] = 1'b1;
        sram_we            = wb_mask_q;
        sram_a             = wb_word_q;
        sram_di            = wb_data_q;
      end
    end
  end

  // Error response sequencer: two-cycle ERROR after an illegal address phase.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StOkay:  if (err_ap) state_d = StErr1;
      StErr1:  state_d = StErr2;
      StErr2:  state_d = err_ap ? StErr1 : StOkay;
      default: state_d = StOkay;
    endcase
  end

  // Read data: selected bank output with buffered bytes forwarded over it.
  always_comb begin
    rd_word = bus.SRAM_DO[{dp_bank_q, 5'b00000} +: 32];
    fwd_hit = wb_valid_q && (wb_bank_q == dp_bank_q) && (wb_word_q == dp_word_q);
    hrdata  = '0;
    if (dp_rd_q && !HRESET) begin
      hrdata = rd_word;
      for (int b = 0; b < 4; b++) begin
        if (fwd_hit && wb_mask_q[b]) hrdata[8*b +: 8] = wb_data_q[8*b +: 8];
      end
    end
  end

  // State registers; reset discards the buffer and any in-flight data phase.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_rd_q    <= 1'b0;
      dp_wr_q    <= 1'b0;
      dp_bank_q  <= '0;
      dp_word_q  <= '0;
      dp_mask_q  <= '0;
      wb_valid_q <= 1'b0;
      wb_bank_q  <= '0;
      wb_word_q  <= '0;
      wb_mask_q  <= '0;
      wb_data_q  <= '0;
      state_q    <= StOkay;
    end else begin
      dp_rd_q    <= dp_rd_d;
      dp_wr_q    <= dp_wr_d;
      dp_bank_q  <= dp_bank_d;
      dp_word_q  <= dp_word_d;
      dp_mask_q  <= dp_mask_d;
      wb_valid_q <= wb_valid_d;
      wb_bank_q  <= wb_bank_d;
      wb_word_q  <= wb_word_d;
      wb_mask_q  <= wb_mask_d;
      wb_data_q  <= wb_data_d;
      state_q    <= state_d;
    end
  end

  // A write address phase never uses the port, so the buffer is empty by its data phase.
  wb_empty_on_write : assert property (@(posedge HCLK) disable iff (HRESET)
    dp_wr_q |-> !wb_valid_q);

  assign bus.HREADYOUT = HRESET || (state_q != StErr1);
  assign bus.HRESP     = !HRESET && (state_q != StOkay);
  assign bus.HRDATA    = hrdata;
  assign bus.SRAM_EN   = sram_en;
  assign bus.SRAM_WE   = sram_we;
  assign bus.SRAM_A    = sram_a;
  assign bus.SRAM_DI   = sram_di;
endmodule

// File: doc/ahb_sram_banked.md
# ahb_sram_banked

AHB-Lite slave that fronts a parametrised array of single-port synchronous SRAM banks (DFFRAM-style, 1-cycle read latency, per-byte write enables). It is the multi-bank successor to the single-bank SRAM hookup in the SoC core: it decodes bank selects from the address, generates byte masks from HSIZE, and returns zero-wait-state reads and writes through a one-entry write buffer with read forwarding. Misaligned transfers get a two-cycle AHB ERROR response. It sits between the AHB-Lite interconnect and the SRAM macros.

## Interface
- NUM_BANKS, 4: number of SRAM banks; legal values 2, 4, 8.
- BANK_AW, 11: word-address width of each bank, giving 2^BANK_AW 32-bit words per bank.
- BSW (localparam): $clog2(NUM_BANKS).

- HCLK  in  1  the single clock; all state updates on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address.
- HTRANS  in  2  transfer type; only NONSEQ/SEQ (HTRANS[1]=1) start a transfer.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  0 = byte, 1 = half, 2 = word; larger values are illegal.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus ready (address phase accepted when 1).
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  32  read data.
- SRAM_EN  out  NUM_BANKS  one-hot bank enable.
- SRAM_WE  out  4  byte write enables; all 0 on a read.
- SRAM_A  out  BANK_AW  word address, shared by all banks.
- SRAM_DI  out  32  write data, shared by all banks.
- SRAM_DO  in  32*NUM_BANKS  read data; bank k is on bits [32k+31:32k].

## Operation
- A transfer is accepted when HSEL & HREADY & HTRANS[1].
- Address fields:
  - word index = HADDR[BANK_AW+1:2]
  - bank = HADDR[BANK_AW+2 +: BSW]
  - upper address bits are ignored, so the space aliases.
- Byte mask:
  - byte: 1<<HADDR[1:0]
  - half: 4'b0011 if HADDR[1]=0, else 4'b1100
  - word: 4'b1111
- Illegal transfer: HSIZE>2, a half at odd HADDR[0], or a word with HADDR[1:0]≠0.
  - No SRAM access and no state update.
  - Error FSM goes OKAY→ERR1→ERR2→OKAY.
- Read address phase: SRAM_EN[bank]=1, SRAM_WE=0, SRAM_A=word, all combinational from HADDR. The bank, word and valid flag are registered for the data phase.
- Read data phase: HRDATA = SRAM_DO[bank].
  - If the buffer is valid and its {bank,word} matches, the buffered bytes under the buffer mask replace the SRAM bytes (forwarding).
  - HRDATA = 0 in non-read-data cycles.
- Write address phase: register bank, word and mask. No SRAM access.
- Write data phase, SRAM port priority:
  1. Read address phase in the same cycle → HWDATA, mask and address are captured into the write buffer (wb_valid←1).
  2. Otherwise direct commit: SRAM_EN[bank]=1, SRAM_WE=mask, SRAM_A=word, SRAM_DI=HWDATA.
- Buffer commit happens in any cycle with no read address phase and no direct write. wb_valid←0 on commit.
- Invariant (assert): wb_valid=0 in every write data phase. A write address phase never uses the port, so the buffer always drains there.
- Error FSM:
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
  - Buffer commits are allowed during ERR1/ERR2.

## Timing
- Reset values:
  - HREADYOUT=1, HRESP=0, HRDATA=0.
  - SRAM_EN=0, SRAM_WE=0, SRAM_A=0, SRAM_DI=0.
  - wb_valid=0, FSM=OKAY, data-phase flags cleared.
- Reset mid-operation: the buffered write is discarded (never committed), and any in-flight data phase is dropped.
- Legal transfers are zero-wait: HREADYOUT=1 throughout. Read data appears in the cycle after the address phase.
- A write reaches the SRAM in its data phase, or at the first free cycle after it if buffered.
- Error latency: ERR1 in the cycle after the illegal address phase, ERR2 in the next cycle.
- An idle bus (HTRANS=IDLE/BUSY or HSEL=0) gives an OKAY response with zero wait.

## Test plan
- Reset: hold HRESET for 2 cycles → HREADYOUT=1, HRESP=0, SRAM_EN=0, SRAM_WE=0. Then release and run IDLE → no SRAM activity.
- Word write then idle: write 0xDEADBEEF @0x10 → in its data phase SRAM_EN=4'b0001, SRAM_WE=4'hF, SRAM_A=4, SRAM_DI=0xDEADBEEF. A later read @0x10 → HRDATA=0xDEADBEEF one cycle after the address phase.
- Back-to-back write/read: write 0x11223344 @0x20 immediately followed by read @0x20 → the write is buffered and HRDATA=0x11223344 by forwarding. The commit (SRAM_WE=4'hF, SRAM_A=8) occurs in the next free cycle.
- Partial forward: memory holds 0x11223344 @0x20. Byte write 0xAB @0x21 followed by read @0x20 → HRDATA=0x1122AB44.
- Bank decode (NUM_BANKS=4, BANK_AW=11): write @0x2004 → SRAM_EN=4'b0010, SRAM_A=1. Write @0x6000 → SRAM_EN=4'b1000, SRAM_A=0.
- Misaligned and reset: word read @0x2 → next cycle HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1, with no SRAM_EN. Separately, buffer a write, then assert HRESET before any free cycle → SRAM_WE stays 0 and the read-back shows old data.
